map_scan_ctrl: RTL and testbench

MAP_SCAN_CTRL -- requirements
Module: map_scan_ctrl

---
 rtl/map_disp_pkg.sv | 40 ++++
 rtl/scan_axis.sv | 48 ++++
 rtl/map_scan_ctrl.sv | 109 ++++++++++
 tb/tb_map_scan_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/map_disp_pkg.sv
// Shared timing defaults and scan state types for the map display path.
package map_disp_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_MAP_X0   = 64;
    localparam int DEF_MAP_Y0   = 48;
    localparam int DEF_MAP_W    = 512;
    localparam int DEF_MAP_H    = 384;
    localparam int DEF_ADDR_W   = 18;

    typedef enum logic [1:0] {
        H_ACT   = 2'd0,
        H_FRONT = 2'd1,
        H_SYNC  = 2'd2,
        H_BACK  = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ACT   = 2'd0,
        V_FRONT = 2'd1,
        V_SYNC  = 2'd2,
        V_BACK  = 2'd3
    } v_state_t;

    // Axis-neutral encoding used inside scan_axis; it matches h_state_t and v_state_t bit for bit.
    typedef enum logic [1:0] {
        AX_ACT   = 2'd0,
        AX_FRONT = 2'd1,
        AX_SYNC  = 2'd2,
        AX_BACK  = 2'd3
    } axis_state_t;

endpackage

// File: rtl/scan_axis.sv
// One scan axis: counts 0..TOTAL-1 on each step and tracks the active/front/sync/back region.
module scan_axis
    import map_disp_pkg::*;
#(
    parameter int  ACTIVE = 640,
    parameter int  FP     = 16,
    parameter int  SYNC   = 96,
    parameter int  BP     = 48,
    localparam int TOTAL  = ACTIVE + FP + SYNC + BP,
    localparam int CNT_W  = $clog2(TOTAL)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_step,
    output logic [CNT_W-1:0] o_cnt,
    output axis_state_t      o_state,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] FP_END   = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC - 1);

    logic [CNT_W-1:0] r_cnt;
    axis_state_t      r_state;

    assign o_cnt   = r_cnt;
    assign o_state = r_state;
    assign o_wrap  = i_step && (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_state <= AX_ACT;
        end else if (i_step) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            case (r_state)
                AX_ACT:   if (r_cnt == ACT_END)  r_state <= AX_FRONT;
                AX_FRONT: if (r_cnt == FP_END)   r_state <= AX_SYNC;
                AX_SYNC:  if (r_cnt == SYNC_END) r_state <= AX_BACK;
                AX_BACK:  if (r_cnt == LAST)     r_state <= AX_ACT;
                default:  r_state <= AX_ACT;
            endcase
        end
    end

endmodule

// File: rtl/map_scan_ctrl.sv
// Raster scan controller: display timing, map window detection and a running map read address.
module map_scan_ctrl #(
    parameter int H_ACTIVE = map_disp_pkg::DEF_H_ACTIVE,
    parameter int H_FP     = map_disp_pkg::DEF_H_FP,
    parameter int H_SYNC   = map_disp_pkg::DEF_H_SYNC,
    parameter int H_BP     = map_disp_pkg::DEF_H_BP,
    parameter int V_ACTIVE = map_disp_pkg::DEF_V_ACTIVE,
    parameter int V_FP     = map_disp_pkg::DEF_V_FP,
    parameter int V_SYNC   = map_disp_pkg::DEF_V_SYNC,
    parameter int V_BP     = map_disp_pkg::DEF_V_BP,
    parameter int MAP_X0   = map_disp_pkg::DEF_MAP_X0,
    parameter int MAP_Y0   = map_disp_pkg::DEF_MAP_Y0,
    parameter int MAP_W    = map_disp_pkg::DEF_MAP_W,
    parameter int MAP_H    = map_disp_pkg::DEF_MAP_H,
    parameter int ADDR_W   = map_disp_pkg::DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pix_ce_i,
    output logic [ADDR_W-1:0] map_addr_o,
    output logic              map_rd_en_o,
    output logic              display_enable_o,
    output logic              map_enable_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_CNT_W = $clog2(H_TOTAL);
    localparam int V_CNT_W = $clog2(V_TOTAL);

    logic [H_CNT_W-1:0]        w_h_cnt;
    logic [V_CNT_W-1:0]        w_v_cnt;
    map_disp_pkg::axis_state_t w_h_axis;
    map_disp_pkg::axis_state_t w_v_axis;
    map_disp_pkg::h_state_t    w_h_state;
    map_disp_pkg::v_state_t    w_v_state;
    logic                      w_h_wrap;
    logic                      w_v_wrap;
    logic                      w_active;
    logic                      w_h_in;
    logic                      w_v_in;
    logic                      w_in_win;
    logic                      w_origin;
    logic [ADDR_W-1:0]         r_addr;

    scan_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_step  (pix_ce_i),
        .o_cnt   (w_h_cnt),
        .o_state (w_h_axis),
        .o_wrap  (w_h_wrap)
    );

    scan_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_step  (w_h_wrap),
        .o_cnt   (w_v_cnt),
        .o_state (w_v_axis),
        .o_wrap  (w_v_wrap)
    );

    assign w_h_state = map_disp_pkg::h_state_t'(w_h_axis);
    assign w_v_state = map_disp_pkg::v_state_t'(w_v_axis);

    // Gating the window with the active flag clips any window that spills past active video.
    assign w_active = (w_h_state == map_disp_pkg::H_ACT) && (w_v_state == map_disp_pkg::V_ACT);
    assign w_h_in   = (int'(w_h_cnt) >= MAP_X0) && (int'(w_h_cnt) < MAP_X0 + MAP_W);
    assign w_v_in   = (int'(w_v_cnt) >= MAP_Y0) && (int'(w_v_cnt) < MAP_Y0 + MAP_H);
    assign w_in_win = w_active && w_h_in && w_v_in;
    assign w_origin = (w_h_cnt == '0) && (w_v_cnt == '0);

    assign map_rd_en_o = pix_ce_i && w_in_win;
    assign map_addr_o  = r_addr;

    // Stage-1 outputs line up with the memory data that returns one enabled cycle after the read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr           <= '0;
            display_enable_o <= 1'b0;
            map_enable_o     <= 1'b0;
            hsync_o          <= 1'b1;
            vsync_o          <= 1'b1;
            frame_start_o    <= 1'b0;
        end else begin
            frame_start_o <= pix_ce_i && w_origin;
            if (pix_ce_i) begin
                display_enable_o <= w_active;
                map_enable_o     <= w_in_win;
                hsync_o          <= (w_h_state != map_disp_pkg::H_SYNC);
                vsync_o          <= (w_v_state != map_disp_pkg::V_SYNC);
                if (w_v_wrap) begin
                    r_addr <= '0;
                end else if (w_in_win) begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_map_scan_ctrl.sv
// Directed bench for map_scan_ctrl: default 640x480 timing plus two shrunken rasters for full-frame checks.
module tb_map_scan_ctrl;

    logic clk   = 1'b0;
    logic rstN  = 1'b1;
    logic pixCe = 1'b0;

    always #5 clk = ~clk;

    logic [17:0] defAddr, smAddr, clAddr;
    logic defRdEn, defDe, defMe, defHsync, defVsync, defFs;
    logic smRdEn, smDe, smMe, smHsync, smVsync, smFs;
    logic clRdEn, clDe, clMe, clHsync, clVsync, clFs;

    map_scan_ctrl uDef (
        .clk_i(clk), .rst_ni(rstN), .pix_ce_i(pixCe),
        .map_addr_o(defAddr), .map_rd_en_o(defRdEn), .display_enable_o(defDe),
        .map_enable_o(defMe), .hsync_o(defHsync), .vsync_o(defVsync), .frame_start_o(defFs)
    );

    // 24 x 13 raster: H 16/2/3/3, V 8/1/2/2, window 8x4 at (4,2).
    map_scan_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .MAP_X0(4), .MAP_Y0(2), .MAP_W(8), .MAP_H(4), .ADDR_W(18)
    ) uSmall (
        .clk_i(clk), .rst_ni(rstN), .pix_ce_i(pixCe),
        .map_addr_o(smAddr), .map_rd_en_o(smRdEn), .display_enable_o(smDe),
        .map_enable_o(smMe), .hsync_o(smHsync), .vsync_o(smVsync), .frame_start_o(smFs)
    );

    // Same raster with a window at x=12 width 10, so only x=12..15 lie in active video.
    map_scan_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .MAP_X0(12), .MAP_Y0(2), .MAP_W(10), .MAP_H(4), .ADDR_W(18)
    ) uClip (
        .clk_i(clk), .rst_ni(rstN), .pix_ce_i(pixCe),
        .map_addr_o(clAddr), .map_rd_en_o(clRdEn), .display_enable_o(clDe),
        .map_enable_o(clMe), .hsync_o(clHsync), .vsync_o(clVsync), .frame_start_o(clFs)
    );

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic applyStimulus(input logic ce);
        @(negedge clk);
        pixCe = ce;
        #1;
    endtask

    // On return, the sample point is the first enabled cycle after release (pixel 0,0).
    task automatic resetRelease();
        @(negedge clk);
        rstN  = 1'b0;
        pixCe = 1'b1;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        #1;
    endtask

    int firstHsLow, secondHsLow, hsLowCnt, firstRd, heldAddr, heldRd, nextAddr, nextRd, firstAddr;
    logic prevHs;
    int sRd, sAddrErr, sExpAddr, sFirstRd, sVsLow, sVsFirst, sFs, sDe, sMe;
    int cRd, cBad, cMeBad, cMe, sEndAddr, cEndAddr, sWrapAddr, sFsAgain;
    int tRd, tRdOff, tFirstRd, tHs, tVs, tFs, tHold;
    logic prevCe;
    logic [21:0] snap;
    int preRd, preAddr, preMe;

    initial begin
        #2;
        pixCe = 1'b1;
        rstN  = 1'b0;
        #1;
        checkOutput("rst_def_flags", 32'({defDe, defMe, defRdEn, defFs, defHsync, defVsync}), 32'b000011);
        checkOutput("rst_def_addr", 32'(defAddr), 0);
        checkOutput("rst_sm_flags", 32'({smDe, smMe, smRdEn, smFs, smHsync, smVsync}), 32'b000011);
        checkOutput("rst_sm_addr", 32'(smAddr), 0);
        checkOutput("rst_cl_flags", 32'({clDe, clMe, clRdEn, clFs, clHsync, clVsync}), 32'b000011);
        checkOutput("rst_cl_addr", 32'(clAddr), 0);

        // Default timing: hsync placement, line period and the first map read at (64,48).
        resetRelease();
        firstHsLow = -1; secondHsLow = -1; hsLowCnt = 0; firstRd = -1; firstAddr = -1;
        heldAddr = -1; heldRd = -1; nextAddr = -1; nextRd = -1; prevHs = 1'b1;
        for (int k = 0; k <= 39264; k++) begin
            if (k > 0) applyStimulus(1'b1);
            if (!defHsync && prevHs) begin
                if (firstHsLow < 0) firstHsLow = k;
                else if (secondHsLow < 0) secondHsLow = k;
            end
            if (k <= 1456 && !defHsync) hsLowCnt++;
            prevHs = defHsync;
            if (defRdEn && firstRd < 0) begin
                firstRd   = k;
                firstAddr = int'(defAddr);
            end
            if (k == 38976) begin
                heldAddr = int'(defAddr);
                heldRd   = defRdEn ? 1 : 0;
            end
            if (k == 39264) begin
                nextAddr = int'(defAddr);
                nextRd   = defRdEn ? 1 : 0;
            end
        end
        checkOutput("hsync_first_low", firstHsLow, 657);
        checkOutput("hsync_width", hsLowCnt, 96);
        checkOutput("line_period", secondHsLow - firstHsLow, 800);
        checkOutput("def_first_read", firstRd, 38464);
        checkOutput("def_first_addr", firstAddr, 0);
        checkOutput("def_hold_rd", heldRd, 0);
        checkOutput("def_hold_addr", heldAddr, 512);
        checkOutput("def_line2_rd", nextRd, 1);
        checkOutput("def_line2_addr", nextAddr, 512);

        // Full frame on the small raster with pix_ce held high.
        resetRelease();
        sRd = 0; sAddrErr = 0; sExpAddr = 0; sFirstRd = -1; sVsLow = 0; sVsFirst = -1;
        sFs = 0; sDe = 0; sMe = 0; cRd = 0; cBad = 0; cMeBad = 0; cMe = 0;
        sEndAddr = -1; cEndAddr = -1; sWrapAddr = -1; sFsAgain = -1;
        for (int k = 0; k <= 313; k++) begin
            if (k > 0) applyStimulus(1'b1);
            if (k <= 311) begin
                if (smRdEn) begin
                    sRd++;
                    if (int'(smAddr) != sExpAddr) sAddrErr++;
                    sExpAddr++;
                    if (sFirstRd < 0) sFirstRd = k;
                end
                if (clRdEn) begin
                    cRd++;
                    if ((k % 24) < 12 || (k % 24) > 15) cBad++;
                end
            end
            if (k >= 1 && k <= 312) begin
                if (!smVsync) begin
                    sVsLow++;
                    if (sVsFirst < 0) sVsFirst = k;
                end
                if (smFs) sFs++;
                if (smDe) sDe++;
                if (smMe) sMe++;
                if (clMe) cMe++;
                if (clMe && ((k - 1) % 24) >= 16) cMeBad++;
            end
            if (k == 311) begin
                sEndAddr = int'(smAddr);
                cEndAddr = int'(clAddr);
            end
            if (k == 312) sWrapAddr = int'(smAddr);
            if (k == 313) sFsAgain = smFs ? 1 : 0;
        end
        checkOutput("sm_read_count", sRd, 32);
        checkOutput("sm_addr_contig", sAddrErr, 0);
        checkOutput("sm_first_read", sFirstRd, 52);
        checkOutput("sm_vsync_low", sVsLow, 48);
        checkOutput("sm_vsync_first", sVsFirst, 217);
        checkOutput("sm_frame_start_cnt", sFs, 1);
        checkOutput("sm_frame_start_next", sFsAgain, 1);
        checkOutput("sm_display_cnt", sDe, 128);
        checkOutput("sm_map_en_cnt", sMe, 32);
        checkOutput("sm_end_addr", sEndAddr, 32);
        checkOutput("sm_wrap_addr", sWrapAddr, 0);
        checkOutput("clip_read_count", cRd, 16);
        checkOutput("clip_read_outside", cBad, 0);
        checkOutput("clip_map_en_outside", cMeBad, 0);
        checkOutput("clip_map_en_cnt", cMe, 16);
        checkOutput("clip_end_addr", cEndAddr, 16);

        // pix_ce alternating 1/0: same enabled-cycle timing, outputs frozen across disabled cycles.
        resetRelease();
        tRd = 0; tRdOff = 0; tFirstRd = -1; tHs = 0; tVs = 0; tFs = 0; tHold = 0;
        prevCe = 1'b1; snap = '0;
        for (int i = 0; i <= 624; i++) begin
            if (i > 0) applyStimulus((i % 2) == 0);
            if (i <= 623) begin
                if (smRdEn) tRd++;
                if (!pixCe && smRdEn) tRdOff++;
                if (smRdEn && tFirstRd < 0) tFirstRd = i;
            end
            if (i >= 1) begin
                if (!smHsync) tHs++;
                if (!smVsync) tVs++;
                if (smFs) tFs++;
                if (!prevCe && (snap != {smAddr, smDe, smMe, smHsync, smVsync})) tHold++;
            end
            snap   = {smAddr, smDe, smMe, smHsync, smVsync};
            prevCe = pixCe;
        end
        checkOutput("tog_read_count", tRd, 32);
        checkOutput("tog_read_when_off", tRdOff, 0);
        checkOutput("tog_first_read", tFirstRd, 104);
        checkOutput("tog_hsync_low", tHs, 78);
        checkOutput("tog_vsync_low", tVs, 96);
        checkOutput("tog_frame_start", tFs, 1);
        checkOutput("tog_hold_violations", tHold, 0);

        // Reset pulse mid-window at (6,3), then restart from (0,0).
        resetRelease();
        for (int k = 1; k <= 78; k++) applyStimulus(1'b1);
        preRd   = smRdEn ? 1 : 0;
        preAddr = int'(smAddr);
        preMe   = smMe ? 1 : 0;
        checkOutput("mid_pre_rd", preRd, 1);
        checkOutput("mid_pre_addr", preAddr, 10);
        checkOutput("mid_pre_map_en", preMe, 1);
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_flags", 32'({smDe, smMe, smRdEn, smFs, smHsync, smVsync}), 32'b000011);
        checkOutput("mid_rst_addr", 32'(smAddr), 0);
        resetRelease();
        checkOutput("mid_restart_addr", 32'(smAddr), 0);
        applyStimulus(1'b1);
        checkOutput("mid_restart_fs", 32'(smFs), 1);
        checkOutput("mid_restart_de", 32'(smDe), 1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
